ctrl_time_event_seq: RTL and testbench



---
 rtl/ctrl_time_event_seq.sv | 142 ++++++++++++++
 tb/tb_ctrl_time_event_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_time_event_seq.sv
// Time-scheduled event sequencer: steps through a programmable (time, value) table
// against a shared step counter. Optional wrap-around repeat via CTRL_TIME_REPEAT_EN.
module ctrl_time_event_seq #(
    parameter int unsigned CNT_W = 12,
    parameter int unsigned VAL_W = 1,
    parameter int unsigned N_EVT = 8,
    localparam int unsigned AW = $clog2(N_EVT)
) (
    input  logic             clk,
    input  logic             sta,
    input  logic [CNT_W-1:0] counter,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [CNT_W-1:0] wr_time,
    input  logic [VAL_W-1:0] wr_value,
    input  logic [VAL_W-1:0] init_value,
    input  logic             arm,
    input  logic             abort,
    output logic [VAL_W-1:0] y,
    output logic             event_stb,
    output logic [AW:0]      event_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDone = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [VAL_W-1:0] y_q, y_d;
    logic [AW:0]      idx_q, idx_d;
    logic             err_q, err_d;
    logic             stb_q, stb_d;
    logic             busy_q, done_q;

    logic [CNT_W-1:0] time_q  [N_EVT];
    logic [VAL_W-1:0] value_q [N_EVT];

    logic             last;
    logic [AW-1:0]    ptr_nxt;
    logic [CNT_W-1:0] cur_time, nxt_time;
    logic             fire;

    // Fire one step early so y shows the new value in the cycle counter == time.
    assign cur_time = time_q[ptr_q];
    assign last     = (ptr_q == AW'(N_EVT - 1));
    assign ptr_nxt  = last ? ptr_q : ptr_q + 1'b1;
    assign nxt_time = last ? '0 : time_q[ptr_nxt];
    assign fire     = (state_q == StRun) && (counter == cur_time - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        y_d     = y_q;
        idx_d   = idx_q;
        err_d   = err_q;
        stb_d   = 1'b0;
        if (arm) begin
            ptr_d   = '0;
            y_d     = init_value;
            idx_d   = '0;
            err_d   = 1'b0;
            state_d = (time_q[0] == '0) ? StDone : StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (abort) begin
                        state_d = StIdle;
                    end else if (fire) begin
                        y_d   = value_q[ptr_q];
                        stb_d = 1'b1;
                        idx_d = {1'b0, ptr_q} + (AW + 1)'(1);
                        if (last || nxt_time == '0) begin
                            state_d = StDone;
                        end else if (nxt_time <= cur_time) begin
                            err_d   = 1'b1;
                            state_d = StDone;
                        end else begin
                            ptr_d = ptr_nxt;
                        end
                    end
                end
                StDone: begin
`ifdef CTRL_TIME_REPEAT_EN
                    // Restart the schedule at each counter wrap unless it ended in error.
                    if (!err_q && counter == '1 && time_q[0] != '0) begin
                        ptr_d   = '0;
                        y_d     = init_value;
                        idx_d   = '0;
                        state_d = StRun;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sta) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            stb_q   <= stb_d;
            busy_q  <= (state_d == StRun);
            done_q  <= (state_d == StDone);
        end
    end

    // Writes in RUN are dropped; an arm in the same cycle still sees the old table.
    always_ff @(posedge clk) begin
        if (sta) begin
            for (int i = 0; i < N_EVT; i++) begin
                time_q[i]  <= '0;
                value_q[i] <= '0;
            end
        end else if (wr_en && state_q != StRun) begin
            time_q[wr_addr]  <= wr_time;
            value_q[wr_addr] <= wr_value;
        end
    end

    assign y         = y_q;
    assign event_stb = stb_q;
    assign event_idx = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ctrl_time_event_seq.sv
// Directed self-checking bench for ctrl_time_event_seq (main instance plus a 4-bit
// counter instance exercising the optional repeat behaviour).
module tb_ctrl_time_event_seq;

`ifdef CTRL_TIME_REPEAT_EN
    localparam bit RepeatEn = 1'b1;
`else
    localparam bit RepeatEn = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        sta;
    logic [11:0] counter;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [11:0] wr_time;
    logic [3:0]  wr_value;
    logic [3:0]  init_value;
    logic        arm;
    logic        abort;
    logic [3:0]  y;
    logic        event_stb;
    logic [3:0]  event_idx;
    logic        busy, done, err;

    logic [3:0]  r_counter;
    logic        r_wr_en;
    logic [2:0]  r_wr_addr;
    logic [3:0]  r_wr_time;
    logic [0:0]  r_wr_value;
    logic [0:0]  r_init;
    logic        r_arm;
    logic        r_abort;
    logic [0:0]  r_y;
    logic        r_stb;
    logic [3:0]  r_idx;
    logic        r_busy, r_done, r_err;

    assign r_counter = counter[3:0];

    int checks = 0;
    int errors = 0;

    ctrl_time_event_seq #(.CNT_W(12), .VAL_W(4), .N_EVT(8)) u_dut (
        .clk(clk), .sta(sta), .counter(counter), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_time(wr_time), .wr_value(wr_value), .init_value(init_value), .arm(arm),
        .abort(abort), .y(y), .event_stb(event_stb), .event_idx(event_idx), .busy(busy),
        .done(done), .err(err)
    );

    ctrl_time_event_seq #(.CNT_W(4), .VAL_W(1), .N_EVT(8)) u_rep (
        .clk(clk), .sta(sta), .counter(r_counter), .wr_en(r_wr_en), .wr_addr(r_wr_addr),
        .wr_time(r_wr_time), .wr_value(r_wr_value), .init_value(r_init), .arm(r_arm),
        .abort(r_abort), .y(r_y), .event_stb(r_stb), .event_idx(r_idx), .busy(r_busy),
        .done(r_done), .err(r_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        counter = counter + 12'd1;
    endtask

    task automatic wr(input int a, input int t, input int v);
        wr_en    = 1'b1;
        wr_addr  = 3'(a);
        wr_time  = 12'(t);
        wr_value = 4'(v);
        step();
        wr_en    = 1'b0;
    endtask

    task automatic r_wr(input int a, input int t, input int v);
        r_wr_en    = 1'b1;
        r_wr_addr  = 3'(a);
        r_wr_time  = 4'(t);
        r_wr_value = 1'(v);
        step();
        r_wr_en    = 1'b0;
    endtask

    task automatic adv_to(input int n);
        for (int i = 0; i < 4096 && int'(counter) != n; i++) step();
    endtask

    task automatic do_arm();
        counter = '0;
        arm     = 1'b1;
        step();
        arm     = 1'b0;
    endtask

    initial begin
        sta = 1'b1; counter = '0; wr_en = 1'b0; wr_addr = '0; wr_time = '0; wr_value = '0;
        init_value = '0; arm = 1'b0; abort = 1'b0;
        r_wr_en = 1'b0; r_wr_addr = '0; r_wr_time = '0; r_wr_value = '0; r_init = '0;
        r_arm = 1'b0; r_abort = 1'b0;
        step();
        step();
        sta = 1'b0;
        chk("rst_y", 32'(y), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_idx", 32'(event_idx), 0);
        chk("rst_stb", 32'(event_stb), 0);

        // Basic two-event schedule
        wr(0, 5, 1); wr(1, 9, 0); wr(2, 0, 0);
        do_arm();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_y_init", 32'(y), 0);
        adv_to(5);
        chk("t1_y5", 32'(y), 1);
        chk("t1_stb5", 32'(event_stb), 1);
        chk("t1_idx5", 32'(event_idx), 1);
        step();
        chk("t1_stb6", 32'(event_stb), 0);
        adv_to(9);
        chk("t1_y9", 32'(y), 0);
        chk("t1_stb9", 32'(event_stb), 1);
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_idx", 32'(event_idx), 2);

        // Full table, VAL_W=4
        for (int k = 0; k < 8; k++) wr(k, 10 * (k + 1), k + 1);
        init_value = 4'hf;
        do_arm();
        chk("t2_y_init", 32'(y), 15);
        for (int k = 0; k < 8; k++) begin
            adv_to(10 * (k + 1));
            chk("t2_y", 32'(y), 32'(k + 1));
            chk("t2_stb", 32'(event_stb), 1);
        end
        chk("t2_done", 32'(done), 1);
        chk("t2_idx", 32'(event_idx), 8);
        chk("t2_err", 32'(err), 0);
        init_value = '0;

        // Non-ascending times
        wr(0, 20, 3); wr(1, 15, 5);
        do_arm();
        chk("t3_err_clr", 32'(err), 0);
        adv_to(20);
        chk("t3_y", 32'(y), 3);
        chk("t3_err", 32'(err), 1);
        chk("t3_done", 32'(done), 1);
        chk("t3_idx", 32'(event_idx), 1);
        adv_to(25);
        chk("t3_y_hold", 32'(y), 3);
        chk("t3_done_hold", 32'(done), 1);

        // Abort, ignored write in RUN
        wr(0, 5, 1); wr(1, 9, 0); wr(2, 0, 0);
        do_arm();
        wr(0, 2, 0);
        chk("t4_stb2", 32'(event_stb), 0);
        chk("t4_y2", 32'(y), 0);
        adv_to(5);
        chk("t4_y5", 32'(y), 1);
        chk("t4_stb5", 32'(event_stb), 1);
        adv_to(7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_ab_busy", 32'(busy), 0);
        chk("t4_ab_done", 32'(done), 0);
        chk("t4_ab_y", 32'(y), 1);
        chk("t4_ab_idx", 32'(event_idx), 1);
        adv_to(10);
        chk("t4_idle_y", 32'(y), 1);
        chk("t4_idle_stb", 32'(event_stb), 0);

        // Abort coincident with fire; write in IDLE takes effect
        wr(0, 4, 1);
        do_arm();
        adv_to(3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4b_y", 32'(y), 0);
        chk("t4b_stb", 32'(event_stb), 0);
        chk("t4b_busy", 32'(busy), 0);
        chk("t4b_idx", 32'(event_idx), 0);
        do_arm();
        adv_to(4);
        chk("t4c_y", 32'(y), 1);
        chk("t4c_stb", 32'(event_stb), 1);

        // Reset mid-RUN clears table
        adv_to(6);
        chk("t5_busy", 32'(busy), 1);
        sta = 1'b1;
        step();
        sta = 1'b0;
        chk("t5_y", 32'(y), 0);
        chk("t5_busy0", 32'(busy), 0);
        chk("t5_idx", 32'(event_idx), 0);
        chk("t5_done0", 32'(done), 0);
        do_arm();
        chk("t5_done", 32'(done), 1);
        chk("t5_busy_arm", 32'(busy), 0);

        // arm with write: arm sees old table
        wr_en = 1'b1; wr_addr = 3'd0; wr_time = 12'd3; wr_value = 4'd1;
        counter = '0; arm = 1'b1;
        step();
        arm = 1'b0; wr_en = 1'b0;
        chk("t5_armwr_done", 32'(done), 1);
        do_arm();
        chk("t5_armwr_busy", 32'(busy), 1);

        // Repeat instance, 4-bit counter
        r_wr(0, 3, 1); r_wr(1, 6, 0);
        counter = '0;
        r_arm = 1'b1;
        step();
        r_arm = 1'b0;
        for (int i = 0; i < 48; i++) begin
            int c;
            logic e;
            c = int'(counter);
            e = (c % 16 >= 3) && (c % 16 <= 5) && (c < 16 || RepeatEn);
            chk("t6_y", 32'(r_y), 32'(e));
            step();
        end
        chk("t6_err", 32'(r_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
